// File: rtl/seg7_mmio_regs.sv
// seg7_mmio_regs: bus register slave feeding the 8-digit seven-segment driver.
// Software writes digit nibbles and digit enables into shadow registers. A
// commit copies them into the live registers in one step. An optional blink
// generator gates the enables. Every output is a flop, so the driver never
// sees a half-updated value.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   req, we, addr     one transfer per cycle with req=1; addr[3:2] selects
//                     DATA / EN / CTRL / STATUS
//   wdata, be         write data and byte enables
//   rdata, ack        registered read data and ack, one cycle after req
//   SEG7_data         live digit nibbles
//   SEG7_en           live digit enables, gated by the blink phase
module seg7_mmio_regs #(
  parameter int unsigned PRESCALE = 50000,
  parameter logic [7:0]  EN_RST   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [31:0] SEG7_data,
  output logic [7:0]  SEG7_en
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [31:0]   shadow_data_q, shadow_data_d;
  logic [7:0]    shadow_en_q,   shadow_en_d;
  logic [31:0]   live_data_q,   live_data_d;
  logic [7:0]    live_en_q,     live_en_d;
  logic [7:0]    seg7_en_q,     seg7_en_d;
  logic          blink_en_q,    blink_en_d;
  logic          auto_commit_q, auto_commit_d;
  logic [15:0]   half_period_q, half_period_d;
  logic          pending_q,     pending_d;
  logic [PW-1:0] presc_q,       presc_d;
  logic [15:0]   tick_cnt_q,    tick_cnt_d;
  logic          phase_q,       phase_d;
  logic          ack_q,         ack_d;
  logic [31:0]   rdata_q,       rdata_d;

  logic       wr_data_s, wr_en_s, wr_ctrl_s, rd_s;
  logic       commit_manual_s, commit_auto_s, tick_s, blink_restart_s;

  // Next-state logic for the register file, commit path, blink timer and bus reply.
  always_comb begin
    rd_s      = req & ~we;
    wr_data_s = req & we & (addr[3:2] == 2'd0);
    wr_en_s   = req & we & (addr[3:2] == 2'd1);
    wr_ctrl_s = req & we & (addr[3:2] == 2'd2);

    // Shadow data: byte-wise merge.
    shadow_data_d = shadow_data_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_data_s && be[i]) begin
        shadow_data_d[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        shadow_data_d[8*i +: 8] = shadow_data_q[8*i +: 8];
      end
    end

    if (wr_en_s && be[0]) begin
      shadow_en_d = wdata[7:0];
    end else begin
      shadow_en_d = shadow_en_q;
    end

    // CTRL fields: byte 0 holds the flags, bytes 2-3 hold half_period.
    if (wr_ctrl_s && be[0]) begin
      blink_en_d    = wdata[0];
      auto_commit_d = wdata[1];
    end else begin
      blink_en_d    = blink_en_q;
      auto_commit_d = auto_commit_q;
    end
    half_period_d = half_period_q;
    if (wr_ctrl_s && be[2]) begin
      half_period_d[7:0] = wdata[23:16];
    end else begin
      half_period_d[7:0] = half_period_q[7:0];
    end
    if (wr_ctrl_s && be[3]) begin
      half_period_d[15:8] = wdata[31:24];
    end else begin
      half_period_d[15:8] = half_period_q[15:8];
    end

    // A manual commit publishes the shadow as it was before this cycle.
    // An auto commit publishes the value being written now.
    commit_manual_s = wr_ctrl_s & be[0] & wdata[2];
    commit_auto_s   = auto_commit_q & (wr_data_s | wr_en_s);
    if (commit_manual_s) begin
      live_data_d = shadow_data_q;
      live_en_d   = shadow_en_q;
    end else if (commit_auto_s) begin
      live_data_d = shadow_data_d;
      live_en_d   = shadow_en_d;
    end else begin
      live_data_d = live_data_q;
      live_en_d   = live_en_q;
    end

    // If a commit and a set happen in the same cycle, the commit wins.
    if (commit_manual_s || commit_auto_s) begin
      pending_d = 1'b0;
    end else if ((wr_data_s || wr_en_s) && (be != 4'd0) && !auto_commit_q) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    tick_s = (presc_q == PRESC_MAX);
    if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Touching the flags or half_period restarts the blink in the visible phase.
    blink_restart_s = wr_ctrl_s & ((be[3:2] != 2'b00) | be[0]);
    if (blink_restart_s || (half_period_q == 16'd0)) begin
      tick_cnt_d = 16'd0;
      phase_d    = 1'b1;
    end else if (tick_s) begin
      if (tick_cnt_q == (half_period_q - 16'd1)) begin
        tick_cnt_d = 16'd0;
        phase_d    = ~phase_q;
      end else begin
        tick_cnt_d = tick_cnt_q + 16'd1;
        phase_d    = phase_q;
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
      phase_d    = phase_q;
    end

    // Gating uses next-state values, so a restart or commit shows up on the
    // driver in the same cycle as the ack.
    seg7_en_d = live_en_d & {8{phase_d | ~blink_en_d}};

    ack_d = req;
    if (rd_s) begin
      case (addr[3:2])
        2'd0:    rdata_d = shadow_data_q;
        2'd1:    rdata_d = {24'd0, shadow_en_q};
        2'd2:    rdata_d = {half_period_q, 14'd0, auto_commit_q, blink_en_q};
        2'd3:    rdata_d = {30'd0, pending_q, phase_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_data_q <= 32'd0;
      shadow_en_q   <= EN_RST;
      live_data_q   <= 32'd0;
      live_en_q     <= EN_RST;
      seg7_en_q     <= EN_RST;
      blink_en_q    <= 1'b0;
      auto_commit_q <= 1'b0;
      half_period_q <= 16'd0;
      pending_q     <= 1'b0;
      presc_q       <= '0;
      tick_cnt_q    <= 16'd0;
      phase_q       <= 1'b1;
      ack_q         <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      live_data_q   <= live_data_d;
      live_en_q     <= live_en_d;
      seg7_en_q     <= seg7_en_d;
      blink_en_q    <= blink_en_d;
      auto_commit_q <= auto_commit_d;
      half_period_q <= half_period_d;
      pending_q     <= pending_d;
      presc_q       <= presc_d;
      tick_cnt_q    <= tick_cnt_d;
      phase_q       <= phase_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign SEG7_data = live_data_q;
  assign SEG7_en   = seg7_en_q;

endmodule
